// File: rtl/stim_sequencer_pkg.sv
// Shared types and opcode field positions for the b10 stimulus sequencer.
package stim_pkg;

  localparam int OP_W    = 12;

  localparam int R       = 0;
  localparam int G       = 1;
  localparam int KEY     = 2;
  localparam int START   = 3;
  localparam int TEST    = 4;
  localparam int RTS     = 5;
  localparam int RTR     = 6;
  localparam int VIN_LSB = 7;
  localparam int VIN_MSB = 10;
  localparam int OBS     = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_APPLY    = 3'd2,
    ST_WAIT_CTS = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/stim_sequencer_hs_timeout.sv
// Handshake timeout counter: counts cycles spent waiting for cts and flags
// the cycle on which the TMO-th consecutive low cycle is reached.
module hs_timeout #(
  parameter int TMO = 15
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic hit
);

  logic [7:0] cnt;

  // Cleared when the sequencer enters WAIT_CTS, advanced on each low-cts cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (count) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Hit on the cycle that would complete TMO low cycles, so the exit edge
  // lands exactly TMO cycles after entry.
  assign hit = count && (cnt == 8'(TMO - 1));

endmodule

// File: rtl/stim_sequencer.sv
// Opcode player for the b10 core: fetches 12-bit opcodes from a synchronous
// program RAM, registers them onto the b10 input pins, and optionally stalls
// on the rts/cts handshake with a timeout.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TMO    = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              halt,
  input  logic              sync_en,
  input  logic [ADDR_W-1:0] prog_len,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [OP_W-1:0]   mem_rdata,
  input  logic              cts,
  output logic              r_button,
  output logic              g_button,
  output logic              key,
  output logic              start,
  output logic              test,
  output logic              rts,
  output logic              rtr,
  output logic              obs,
  output logic [3:0]        v_in,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [1:0]        rst_pipe;
  logic              rst_n;
  state_t            state;
  state_t            next_state;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] pc_inc;
  logic              accept_go;
  logic              tmo_clear;
  logic              tmo_count;
  logic              tmo_hit;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n     = rst_pipe[1];
  assign pc_inc    = pc + ADDR_W'(1);
  assign accept_go = go && !halt && ((state == ST_IDLE) || (state == ST_DONE));
  assign tmo_count = (state == ST_WAIT_CTS) && !cts;

  hs_timeout #(
    .TMO (TMO)
  ) u_hs_timeout (
    .clock (clock),
    .rst_n (rst_n),
    .clear (tmo_clear),
    .count (tmo_count),
    .hit   (tmo_hit)
  );

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; halt overrides every transition out of a non-idle state.
  always_comb begin
    next_state = state;
    tmo_clear  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept_go) begin
          next_state = (prog_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        next_state = ST_APPLY;
      end
      ST_APPLY: begin
        if (sync_en && mem_rdata[RTS]) begin
          next_state = ST_WAIT_CTS;
          tmo_clear  = 1'b1;
        end else if (pc_inc == len) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_FETCH;
        end
      end
      ST_WAIT_CTS: begin
        // pc was already advanced when the opcode was applied.
        if (cts || tmo_hit) begin
          next_state = (pc == len) ? ST_DONE : ST_FETCH;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (halt && (state != ST_IDLE)) begin
      next_state = ST_IDLE;
    end
  end

  // Opcode register, program counter, run length and sticky timeout flag.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      opcode <= '0;
      pc     <= '0;
      len    <= '0;
      err    <= 1'b0;
    end else if (halt && (state != ST_IDLE)) begin
      opcode <= '0;
      pc     <= '0;
    end else if (accept_go) begin
      len    <= prog_len;
      pc     <= '0;
      err    <= 1'b0;
    end else if (state == ST_APPLY) begin
      opcode <= mem_rdata;
      pc     <= pc_inc;
    end else if (tmo_hit) begin
      err    <= 1'b1;
    end
  end

  assign mem_en   = (state == ST_FETCH);
  assign mem_addr = pc;
  assign busy     = (state == ST_FETCH) || (state == ST_APPLY) || (state == ST_WAIT_CTS);
  assign done     = (state == ST_DONE);

  assign r_button = opcode[R];
  assign g_button = opcode[G];
  assign key      = opcode[KEY];
  assign start    = opcode[START];
  assign test     = opcode[TEST];
  assign rts      = opcode[RTS];
  assign rtr      = opcode[RTR];
  assign v_in     = opcode[VIN_MSB:VIN_LSB];
  assign obs      = opcode[OBS];

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: hand-built vector table, directed handshake,
// halt and reset sequences, and randomized programs against an event model.
module tb_stim_sequencer;

  localparam int ADDR_W = 10;
  localparam int TMO    = 15;
  localparam int MAXC   = 1024;

  logic              clock = 1'b0;
  logic              reset;
  logic              go;
  logic              halt;
  logic              sync_en;
  logic [ADDR_W-1:0] prog_len;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_rdata = 12'h000;
  logic              cts;
  logic              r_button, g_button, key, start, test, rts, rtr, obs;
  logic [3:0]        v_in;
  logic [ADDR_W-1:0] pc;
  logic              busy, done, err;

  logic [11:0] ram [0:(1<<ADDR_W)-1];
  bit          cts_sched [MAXC];

  int n_chk  = 0;
  int n_fail = 0;

  int a_e [64];
  int f_e [64];
  int tmo_edge;
  int done_e;

  typedef struct packed {
    logic [11:0] op;
    logic        r, g, k, s, t, rs, rr;
    logic [3:0]  vin;
    logic        ob;
  } vec_t;

  vec_t tbl [7];

  stim_sequencer #(
    .ADDR_W (ADDR_W),
    .TMO    (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .halt      (halt),
    .sync_en   (sync_en),
    .prog_len  (prog_len),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cts       (cts),
    .r_button  (r_button),
    .g_button  (g_button),
    .key       (key),
    .start     (start),
    .test      (test),
    .rts       (rts),
    .rtr       (rtr),
    .obs       (obs),
    .v_in      (v_in),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clock = ~clock;

  // Synchronous program RAM: data valid the cycle after the read enable.
  always @(posedge clock) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic logic [11:0] pins_now();
    return {obs, v_in, rtr, rts, test, start, key, g_button, r_button};
  endfunction

  // Event-level model: go sampled at edge 1, FETCH after edge f, the opcode
  // appears on the pins after edge f+2; a stall then waits for the first cts
  // high cycle or TMO low cycles.
  task automatic build_model(input int len, input bit sync);
    int f;
    int a;
    int ex;
    tmo_edge = 1 << 30;
    f = 1;
    for (int i = 0; i < len; i++) begin
      f_e[i] = f;
      a      = f + 2;
      a_e[i] = a;
      ex     = a;
      if (sync && ram[i][5]) begin
        ex = -1;
        for (int k = 0; k < TMO && ex < 0; k++) begin
          if (cts_sched[a + k]) ex = a + k + 1;
        end
        if (ex < 0) begin
          ex = a + TMO;
          if (tmo_edge > ex) tmo_edge = ex;
        end
      end
      f = ex;
    end
    done_e = f;
  endtask

  task automatic run_random(input int len, input bit sync, input logic [11:0] prev_op);
    logic [11:0] eop;
    int          epc;
    logic        emem;
    int          eaddr;
    build_model(len, sync);
    step();
    sync_en  = sync;
    prog_len = ADDR_W'(len);
    go       = 1'b1;
    cts      = cts_sched[0];
    for (int c = 1; c <= done_e + 2; c++) begin
      step();
      eop   = prev_op;
      epc   = 0;
      emem  = 1'b0;
      eaddr = 0;
      for (int i = 0; i < len; i++) begin
        if (a_e[i] <= c) begin
          eop = ram[i];
          epc++;
        end
        if (f_e[i] == c) begin
          emem  = 1'b1;
          eaddr = i;
        end
      end
      check("rnd_pins", pins_now(), eop);
      check("rnd_pc", pc, epc);
      check("rnd_mem_en", mem_en, emem);
      if (emem) check("rnd_mem_addr", mem_addr, eaddr);
      check("rnd_busy", busy, c < done_e);
      check("rnd_done", done, c >= done_e);
      check("rnd_err", err, c >= tmo_edge);
      go  = 1'b0;
      cts = cts_sched[c];
    end
    cts = 1'b0;
  endtask

  initial begin
    logic [11:0] model_op;
    int          ptab [4];
    int          len;
    bit          sync;
    int          p;

    ptab = '{0, 10, 35, 80};

    tbl[0] = {12'h001, 7'b1000000, 4'h0, 1'b0};
    tbl[1] = {12'h00A, 7'b0101000, 4'h0, 1'b0};
    tbl[2] = {12'h781, 7'b1000000, 4'hF, 1'b0};
    tbl[3] = {12'h800, 7'b0000000, 4'h0, 1'b1};
    tbl[4] = {12'h054, 7'b0010101, 4'h0, 1'b0};
    tbl[5] = {12'h0A3, 7'b1100010, 4'h1, 1'b0};
    tbl[6] = {12'h510, 7'b0000100, 4'hA, 1'b0};

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 12'h000;

    reset = 1'b0; go = 1'b0; halt = 1'b0; sync_en = 1'b0;
    prog_len = '0; cts = 1'b0;

    // Reset state.
    step(); step();
    check("rst_pins", pins_now(), 12'h000);
    check("rst_pc", pc, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    repeat (4) step();

    // Basic three-opcode program.
    ram[0] = 12'h001; ram[1] = 12'h00A; ram[2] = 12'h781;
    sync_en = 1'b0; prog_len = 10'd3; go = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      go = 1'b0;
      if (c == 1) check("tp_mem_en_c1", mem_en, 1);
      if (c == 3) check("tp_r_c3", r_button, 1);
      if (c == 5) begin
        check("tp_start_c5", start, 1);
        check("tp_g_c5", g_button, 1);
      end
      if (c == 6) check("tp_done_c6", done, 0);
      if (c == 7) begin
        check("tp_vin_c7", v_in, 4'hF);
        check("tp_r_c7", r_button, 1);
        check("tp_done_c7", done, 1);
        check("tp_pc_c7", pc, 3);
      end
    end

    // Table of opcodes: each vector held two cycles from cycle 3.
    for (int i = 0; i < 7; i++) ram[i] = tbl[i].op;
    step();
    prog_len = 10'd7; go = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      go = 1'b0;
      if (c >= 3) begin
        check("tbl_pins", {r_button, g_button, key, start, test, rts, rtr, v_in, obs},
              {tbl[(c-3)/2].r, tbl[(c-3)/2].g, tbl[(c-3)/2].k, tbl[(c-3)/2].s,
               tbl[(c-3)/2].t, tbl[(c-3)/2].rs, tbl[(c-3)/2].rr, tbl[(c-3)/2].vin,
               tbl[(c-3)/2].ob});
      end
      if (c == 14) check("tbl_done_c14", done, 0);
      if (c == 15) check("tbl_done_c15", done, 1);
    end

    // rts stall: cts low four cycles, then high.
    ram[0] = 12'h020; ram[1] = 12'h001;
    step();
    sync_en = 1'b1; prog_len = 10'd2; go = 1'b1; cts = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step();
      go = 1'b0;
      if (c >= 3 && c <= 7) begin
        check("wc_rts", rts, 1);
        check("wc_mem_en_low", mem_en, 0);
        check("wc_busy", busy, 1);
      end
      if (c == 8) begin
        check("wc_fetch_c8", mem_en, 1);
        check("wc_addr_c8", mem_addr, 1);
        check("wc_err_c8", err, 0);
      end
      if (c == 9) check("wc_done_c9", done, 0);
      if (c == 10) begin
        check("wc_done_c10", done, 1);
        check("wc_r_c10", r_button, 1);
      end
      cts = (c >= 7);
    end
    cts = 1'b0;

    // Handshake timeout with cts stuck low.
    ram[0] = 12'h020; ram[1] = 12'h002;
    step();
    prog_len = 10'd2; go = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      go = 1'b0;
      if (c == 17) begin
        check("to_err_c17", err, 0);
        check("to_mem_en_c17", mem_en, 0);
      end
      if (c == 18) begin
        check("to_err_c18", err, 1);
        check("to_fetch_c18", mem_en, 1);
      end
      if (c == 20) begin
        check("to_done_c20", done, 1);
        check("to_g_c20", g_button, 1);
        check("to_err_c20", err, 1);
      end
    end
    // A new go clears the sticky flag.
    ram[0] = 12'h001;
    sync_en = 1'b0; prog_len = 10'd1; go = 1'b1;
    step();
    go = 1'b0;
    check("to_err_cleared", err, 0);
    repeat (3) step();
    check("to_rerun_done", done, 1);

    // Halt on the second APPLY of a run that has already timed out.
    ram[0] = 12'h020; ram[1] = 12'h001; ram[2] = 12'h002; ram[3] = 12'h004;
    step();
    sync_en = 1'b1; prog_len = 10'd4; go = 1'b1; cts = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      step();
      go = 1'b0;
      if (c == 19) begin
        check("halt_busy_c19", busy, 1);
        check("halt_err_c19", err, 1);
        halt = 1'b1;
      end
    end
    step();
    halt = 1'b0;
    check("halt_busy", busy, 0);
    check("halt_done", done, 0);
    check("halt_pins", pins_now(), 12'h000);
    check("halt_pc", pc, 0);
    check("halt_mem_en", mem_en, 0);
    check("halt_err_kept", err, 1);

    // halt and go together in IDLE: stays idle.
    go = 1'b1; halt = 1'b1;
    step();
    go = 1'b0; halt = 1'b0;
    check("hg_idle_busy", busy, 0);
    check("hg_idle_mem_en", mem_en, 0);

    // Empty program.
    prog_len = 10'd0; go = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      go = 1'b0;
      check("len0_mem_en", mem_en, 0);
      check("len0_done", done, 1);
    end
    // halt and go together in DONE: halt wins.
    prog_len = 10'd2; go = 1'b1; halt = 1'b1;
    step();
    go = 1'b0; halt = 1'b0;
    check("hg_done_done", done, 0);
    check("hg_done_busy", busy, 0);
    check("hg_done_mem_en", mem_en, 0);

    // halt and cts together in WAIT_CTS: halt wins.
    ram[0] = 12'h020; ram[1] = 12'h001;
    sync_en = 1'b1; prog_len = 10'd2; go = 1'b1; cts = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      go = 1'b0;
      if (c == 4) begin
        check("hc_rts_c4", rts, 1);
        halt = 1'b1;
        cts  = 1'b1;
      end
    end
    step();
    halt = 1'b0; cts = 1'b0;
    check("hc_busy", busy, 0);
    check("hc_pc", pc, 0);
    check("hc_rts", rts, 0);
    check("hc_mem_en", mem_en, 0);

    // Asynchronous reset in the middle of WAIT_CTS.
    ram[0] = 12'h020;
    step();
    prog_len = 10'd1; go = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      go = 1'b0;
    end
    check("ar_busy_before", busy, 1);
    check("ar_rts_before", rts, 1);
    #1 reset = 1'b0;
    #1;
    check("ar_rts", rts, 0);
    check("ar_pc", pc, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_err", err, 0);
    step(); step();
    reset = 1'b1;
    repeat (4) step();
    check("ar_idle_busy", busy, 0);
    check("ar_idle_done", done, 0);
    check("ar_idle_pins", pins_now(), 12'h000);

    // Randomized programs against the event model.
    model_op = 12'h000;
    for (int r = 0; r < 14; r++) begin
      len  = int'($urandom_range(0, 12));
      sync = 1'($urandom_range(0, 1));
      p    = ptab[$urandom_range(0, 3)];
      for (int i = 0; i < len; i++) ram[i] = 12'($urandom);
      for (int c = 0; c < MAXC; c++) cts_sched[c] = ($urandom_range(0, 99) < p);
      run_random(len, sync, model_op);
      if (len > 0) model_op = ram[len - 1];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Synthesizable replacement for the behavioural opcode player that drives the b10 core. Fetches 12-bit stimulus opcodes from a synchronous program RAM and decodes each into the b10 input pins. It can stall on the core's rts/cts handshake before advancing. It sits between the program RAM and the b10 instance, so stimulus replay runs identically in simulation and on FPGA.

## Interface
Parameters:
- ADDR_W, 10, program RAM address width
- TMO, 15, max cycles to wait for cts before declaring a handshake timeout (1..255)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- go  in  1  start/restart program from address 0 (sampled in IDLE or DONE)
- halt  in  1  abort run, return to IDLE (priority over go)
- sync_en  in  1  enable rts/cts stall mode
- prog_len  in  ADDR_W  number of opcodes to play; sampled on accepted go
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  12  RAM data, valid one cycle after mem_en
- cts  in  1  handshake acknowledge from b10
- r_button, g_button, key, start, test, rts, rtr, obs  out  1 each  decoded opcode bits 0,1,2,3,4,5,6,11
- v_in  out  4  opcode bits [10:7]
- pc  out  ADDR_W  index of next opcode to fetch
- busy  out  1  high in FETCH, APPLY, WAIT_CTS
- done  out  1  high in DONE
- err  out  1  sticky handshake-timeout flag

## Operation
- States: IDLE, FETCH, APPLY, WAIT_CTS, DONE.
- IDLE: go -> latch prog_len, pc=0, clear err. If prog_len==0, go to DONE; otherwise go to FETCH.
- FETCH: mem_en=1, mem_addr=pc -> APPLY.
- APPLY: register mem_rdata fields onto the b10 outputs, pc<=pc+1.
  - If sync_en and opcode bit 5 (rts) is 1 -> WAIT_CTS, timeout counter cleared.
  - Else if pc+1==prog_len -> DONE.
  - Else -> FETCH.
- WAIT_CTS: outputs hold. Counter increments each cycle cts is low.
  - cts high -> leave via the APPLY exit rule (DONE if pc==prog_len, else FETCH).
  - Counter reaches TMO -> set err, leave the same way.
- DONE: done=1, outputs hold the last vector. go -> restart exactly as from IDLE.
- halt in any state except IDLE -> IDLE next cycle. All b10-drive outputs go to 0, pc=0, err preserved.
- go while busy is ignored.
- pc arithmetic is ADDR_W-bit. prog_len bounds the run, so pc never wraps. prog_len values above the RAM depth are the caller's responsibility.

## Timing
- Reset value 0 for every output, including mem_addr, pc and err. State=IDLE.
- Assertion of reset is immediate and asynchronous. Deassertion is synchronised internally by a 2-flop release.
- go at edge N:
  - edge N+1: FETCH, mem_en high.
  - edge N+2: APPLY, data registered.
  - b10 pins change after edge N+3 (registered outputs).
- Streaming rate without stalls is one vector per 2 cycles. Each vector is held 2 cycles.
- cts is sampled registered-free in WAIT_CTS. A cts already high on the first WAIT_CTS cycle exits after 1 cycle.
- Timeout exit occurs TMO cycles after entering WAIT_CTS with cts held low.
- If halt and go arrive on the same edge, halt wins. If halt and cts arrive on the same edge, halt wins.
- mem_en is low in every state except FETCH.

## Structure
- Package stim_pkg holds:
  - the state enum;
  - opcode bit-position constants: R=0, G=1, KEY=2, START=3, TEST=4, RTS=5, RTR=6, VIN_LSB=7, VIN_MSB=10, OBS=11;
  - OP_W=12.
- One sub-module, hs_timeout: a loadable up-counter with a TMO compare and a hit flag, cleared on entry to WAIT_CTS.
- Top-level FSM, opcode register and pc live in stim_sequencer.

## Test plan
- prog_len=3, sync_en=0, RAM={0x001,0x00A,0x781}, go pulse. Required:
  - r_button=1 at cycle 3; start=1 and g_button=1 at cycle 5; v_in=4'hF and r_button=1 at cycle 7;
  - done=1 at cycle 7; pc=3.
- sync_en=1, opcode 0x020 (rts). Hold cts low 4 cycles, then high: WAIT_CTS lasts 5 cycles, err=0, next fetch follows.
- sync_en=1, TMO=15, cts tied low: err set after exactly 15 WAIT_CTS cycles, program continues to DONE. A following go clears err.
- halt asserted mid-run on the second APPLY: next cycle state=IDLE, all drive outputs 0, pc=0, mem_en=0.
- prog_len=0 with go: DONE after 1 cycle, mem_en never asserted. reset pulsed low mid-WAIT_CTS: all outputs 0 immediately, IDLE after release.
